register_file_sb: RTL and testbench

//  Parametrised 2-read/1-write integer register file with write-to-read bypass,

---
 rtl/register_file_sb.sv | 89 ++++++++
 tb/tb_register_file_sb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// 2-read/1-write register file with write-to-read bypass, optional hardwired r0,
// a per-register pending scoreboard for hazard detection and a raw debug read port.
module register_file_sb #(
   parameter int DATA_N   = 32,
   parameter int SIZE     = 32,
   parameter int ADDR_N   = $clog2(SIZE),
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_N-1:0] w_addr,
   input  logic [DATA_N-1:0] w_data,
   input  logic              issue_en,
   input  logic [ADDR_N-1:0] issue_rd,
   input  logic              flush,
   input  logic [ADDR_N-1:0] r0_addr,
   input  logic [ADDR_N-1:0] r1_addr,
   output logic [DATA_N-1:0] r0_data,
   output logic [DATA_N-1:0] r1_data,
   output logic              r0_busy,
   output logic              r1_busy,
   input  logic [ADDR_N-1:0] dbg_addr,
   output logic [DATA_N-1:0] dbg_data,
   output logic [ADDR_N:0]   pend_cnt
);

   localparam int CNT_W = ADDR_N + 1;

   logic [DATA_N-1:0] regs_q [SIZE];
   logic [DATA_N-1:0] regs_d [SIZE];
   logic [SIZE-1:0]   pend_q, pend_d;
   logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;

   logic wr_ok, issue_ok;
   logic r0_zero, r1_zero, r0_fwd, r1_fwd;

   assign wr_ok    = wr_en && !(ZERO_REG && w_addr == '0);
   assign issue_ok = issue_en && !(ZERO_REG && issue_rd == '0);

   always_comb begin
      // NOTE: every always_comb output is defaulted first so no path can infer a latch.
      for (int i = 0; i < SIZE; i++) regs_d[i] = regs_q[i];
      if (wr_ok) regs_d[w_addr] = w_data;
   end

   // Later assignments win: writeback clear < issue set < flush.
   always_comb begin
      pend_d = pend_q;
      if (wr_en)    pend_d[w_addr]   = 1'b0;
      if (issue_ok) pend_d[issue_rd] = 1'b1;
      if (flush)    pend_d           = '0;
      if (ZERO_REG) pend_d[0]        = 1'b0;
      pend_cnt_d = '0;
      for (int i = 0; i < SIZE; i++) pend_cnt_d = pend_cnt_d + CNT_W'(pend_d[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the array is reset explicitly because reads must return 0 after reset;
         // this prevents mapping it onto a RAM macro, which is acceptable at 32 entries.
         for (int i = 0; i < SIZE; i++) regs_q[i] <= '0;
         pend_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         for (int i = 0; i < SIZE; i++) regs_q[i] <= regs_d[i];
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign r0_zero = ZERO_REG && r0_addr == '0;
   assign r1_zero = ZERO_REG && r1_addr == '0;
   assign r0_fwd  = BYPASS && wr_en && w_addr == r0_addr;
   assign r1_fwd  = BYPASS && wr_en && w_addr == r1_addr;

   // Reads are forced to zero while reset is held so bypassed write data cannot leak.
   assign r0_data = (!rst_n || r0_zero) ? '0 : r0_fwd ? w_data : regs_q[r0_addr];
   assign r1_data = (!rst_n || r1_zero) ? '0 : r1_fwd ? w_data : regs_q[r1_addr];

   assign r0_busy = pend_q[r0_addr] && !r0_fwd && !r0_zero;
   assign r1_busy = pend_q[r1_addr] && !r1_fwd && !r1_zero;

   assign dbg_data = regs_q[dbg_addr];
   assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: stimulus queues expected values, a negedge
// monitor pops them and compares against the live outputs.
module tb_register_file_sb;

   typedef enum int { S_R0D, S_R1D, S_R0B, S_R1B, S_CNT, S_DBG } sel_e;
   typedef struct {
      sel_e        sel;
      string       name;
      logic [31:0] exp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en, issue_en, flush;
   logic [4:0]  w_addr, issue_rd, r0_addr, r1_addr, dbg_addr;
   logic [31:0] w_data;
   logic [31:0] r0_data, r1_data, dbg_data;
   logic        r0_busy, r1_busy;
   logic [5:0]  pend_cnt;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   register_file_sb dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
      .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
      .r0_addr(r0_addr), .r1_addr(r1_addr),
      .r0_data(r0_data), .r1_data(r1_data),
      .r0_busy(r0_busy), .r1_busy(r1_busy),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .pend_cnt(pend_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_v(input sel_e s, input string n, input logic [31:0] v);
      exp_t e;
      e.sel = s; e.name = n; e.exp = v;
      exp_q.push_back(e);
   endtask

   // Advance to just after the next rising edge and return control inputs to idle.
   task automatic cyc();
      @(posedge clk);
      #1;
      wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
   endtask

   // Monitor: outputs are combinational, so sample on the falling edge.
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t e;
         logic [31:0] act;
         e = exp_q.pop_front();
         case (e.sel)
            S_R0D:   act = r0_data;
            S_R1D:   act = r1_data;
            S_R0B:   act = {31'd0, r0_busy};
            S_R1B:   act = {31'd0, r1_busy};
            S_CNT:   act = {26'd0, pend_cnt};
            default: act = dbg_data;
         endcase
         check(e.name, act, e.exp);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
      w_addr = '0; w_data = '0; issue_rd = '0;
      r0_addr = '0; r1_addr = '0; dbg_addr = '0;

      // Reset state
      cyc();
      r0_addr = 5'd5;
      expect_v(S_R0D, "reset_r0_data", 32'h0);
      expect_v(S_CNT, "reset_pend_cnt", 32'd0);
      expect_v(S_R0B, "reset_r0_busy", 32'd0);
      cyc();
      rst_n = 1'b1;

      // Write r5 then reset mid-cycle
      cyc();
      wr_en = 1'b1; w_addr = 5'd5; w_data = 32'hDEAD_BEEF; r0_addr = 5'd5;
      expect_v(S_R0D, "r5_bypass", 32'hDEAD_BEEF);
      cyc();
      issue_en = 1'b1; issue_rd = 5'd10; dbg_addr = 5'd5;
      expect_v(S_R0D, "r5_array", 32'hDEAD_BEEF);
      expect_v(S_DBG, "r5_dbg", 32'hDEAD_BEEF);
      cyc();
      expect_v(S_CNT, "pre_reset_cnt", 32'd1);
      cyc();
      rst_n = 1'b0; wr_en = 1'b1; w_addr = 5'd5; w_data = 32'h0000_CAFE;
      #1;
      expect_v(S_R0D, "async_reset_r0_data", 32'h0);
      expect_v(S_CNT, "async_reset_pend_cnt", 32'd0);
      expect_v(S_DBG, "async_reset_dbg", 32'h0);
      cyc();
      rst_n = 1'b1;
      expect_v(S_R0D, "write_in_reset_discarded", 32'h0);
      expect_v(S_CNT, "issue_in_reset_discarded", 32'd0);

      // Hardwired zero register
      cyc();
      wr_en = 1'b1; w_addr = 5'd0; w_data = 32'h1234; r0_addr = 5'd0;
      issue_en = 1'b1; issue_rd = 5'd0;
      expect_v(S_R0D, "zero_reg_no_bypass", 32'h0);
      cyc();
      dbg_addr = 5'd0;
      expect_v(S_R0D, "zero_reg_read", 32'h0);
      expect_v(S_DBG, "zero_reg_dbg", 32'h0);
      expect_v(S_CNT, "zero_reg_not_pending", 32'd0);
      expect_v(S_R0B, "zero_reg_busy", 32'd0);

      // Bypass on port 1; debug port is never bypassed
      cyc();
      wr_en = 1'b1; w_addr = 5'd7; w_data = 32'h11;
      cyc();
      wr_en = 1'b1; w_addr = 5'd7; w_data = 32'h22; r1_addr = 5'd7; dbg_addr = 5'd7;
      expect_v(S_R1D, "bypass_r1", 32'h22);
      expect_v(S_DBG, "dbg_no_bypass", 32'h11);
      cyc();
      expect_v(S_R1D, "bypass_r1_after", 32'h22);
      expect_v(S_CNT, "write_non_pending_cnt", 32'd0);

      // Scoreboard issue / writeback
      cyc();
      issue_en = 1'b1; issue_rd = 5'd3; r0_addr = 5'd3; r1_addr = 5'd3;
      expect_v(S_R0B, "issue_not_visible_same_cycle", 32'd0);
      expect_v(S_CNT, "issue_cnt_same_cycle", 32'd0);
      cyc();
      expect_v(S_R0B, "r3_busy_p0", 32'd1);
      expect_v(S_R1B, "r3_busy_p1", 32'd1);
      expect_v(S_CNT, "r3_pend_cnt", 32'd1);
      cyc();
      wr_en = 1'b1; w_addr = 5'd3; w_data = 32'h33;
      expect_v(S_R0B, "wb_clears_busy_same_cycle", 32'd0);
      expect_v(S_R0D, "wb_bypass_r3", 32'h33);
      expect_v(S_CNT, "wb_cnt_same_cycle", 32'd1);
      cyc();
      expect_v(S_CNT, "wb_cnt_next", 32'd0);
      expect_v(S_R0B, "wb_busy_next", 32'd0);
      expect_v(S_R0D, "wb_r3_array", 32'h33);

      // Simultaneous issue and writeback on a pending register
      cyc();
      issue_en = 1'b1; issue_rd = 5'd4;
      cyc();
      issue_en = 1'b1; issue_rd = 5'd4; wr_en = 1'b1; w_addr = 5'd4; w_data = 32'h44;
      r0_addr = 5'd4;
      expect_v(S_R0B, "simul_bypass_masks_busy", 32'd0);
      expect_v(S_CNT, "simul_cnt_before", 32'd1);
      cyc();
      expect_v(S_R0B, "simul_still_pending", 32'd1);
      expect_v(S_CNT, "simul_cnt_after", 32'd1);
      expect_v(S_R0D, "simul_data", 32'h44);
      cyc();
      issue_en = 1'b1; issue_rd = 5'd4;
      cyc();
      expect_v(S_CNT, "reissue_no_double_count", 32'd1);
      wr_en = 1'b1; w_addr = 5'd4; w_data = 32'h45;
      cyc();
      expect_v(S_CNT, "r4_cleared", 32'd0);

      // Top register: issue and write in the same cycle of a non-pending reg
      cyc();
      wr_en = 1'b1; w_addr = 5'd31; w_data = 32'hFFFF_FFFF;
      issue_en = 1'b1; issue_rd = 5'd31;
      cyc();
      r1_addr = 5'd31;
      expect_v(S_R1D, "r31_data", 32'hFFFF_FFFF);
      expect_v(S_R1B, "r31_busy", 32'd1);
      expect_v(S_CNT, "r31_cnt", 32'd1);
      cyc();
      wr_en = 1'b1; w_addr = 5'd31; w_data = 32'h0;
      expect_v(S_R1B, "r31_wb_busy", 32'd0);
      expect_v(S_R1D, "r31_wb_bypass", 32'h0);
      cyc();
      expect_v(S_CNT, "r31_cnt_cleared", 32'd0);

      // Flush beats a same-cycle issue
      cyc();
      issue_en = 1'b1; issue_rd = 5'd1;
      cyc();
      issue_en = 1'b1; issue_rd = 5'd2;
      cyc();
      issue_en = 1'b1; issue_rd = 5'd9;
      cyc();
      r0_addr = 5'd1; r1_addr = 5'd9;
      expect_v(S_CNT, "three_pending", 32'd3);
      expect_v(S_R0B, "r1_busy_before_flush", 32'd1);
      expect_v(S_R1B, "r9_busy_before_flush", 32'd1);
      cyc();
      flush = 1'b1; issue_en = 1'b1; issue_rd = 5'd6;
      expect_v(S_CNT, "flush_cnt_same_cycle", 32'd3);
      cyc();
      r0_addr = 5'd6; r1_addr = 5'd1;
      expect_v(S_CNT, "flush_cnt", 32'd0);
      expect_v(S_R0B, "flush_beats_issue", 32'd0);
      expect_v(S_R1B, "flush_r1", 32'd0);
      cyc();
      r0_addr = 5'd2; r1_addr = 5'd9;
      expect_v(S_R0B, "flush_r2", 32'd0);
      expect_v(S_R1B, "flush_r9", 32'd0);

      @(negedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
